fighter_anim_controller: RTL
============================

FIGHTER_ANIM_CONTROLLER -- requirements
Module: fighter_anim_controller

Interface
REQ-001 The module SHALL expose parameter HOLD_TICKS, default 4, giving the anim_ticks each frame persists when ANIM_HOLD_EN is defined; legal range 1..31.
REQ-002 The module SHALL expose parameter COORD_W, default 11, giving the width of the sprite row and column outputs.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 anim_tick  input  1  one-clk frame-rate strobe.
REQ-006 move_req  input  1  level; horizontal movement held.
REQ-007 jump_req  input  1  one-clk pulse; jump request.
REQ-008 attack_req  input  1  one-clk pulse; neutral attack request.
REQ-009 on_ground  input  1  level; character is grounded.
REQ-010 anim_row  output  COORD_W  sprite-sheet row of the current frame.
REQ-011 anim_col  output  COORD_W  sprite-sheet column of the current frame.
REQ-012 busy  output  1  high while in JUMP or ATTACK, the one-shot states.
REQ-013 anim_done  output  1  one-clk pulse when an ATTACK sequence completes.

Function
REQ-014 The states SHALL be IDLE, RUN, JUMP, FALL and ATTACK, each selecting frames by a 2-bit frame index.
REQ-015 The frame table (row,col) SHALL be:
- IDLE: (0,0).
- RUN: (30,0), (30,23), (30,46), looping.
- JUMP: (60,0), (60,23), one-shot.
- FALL: (90,0), held.
- ATTACK: (90,23), (120,0), (120,23), one-shot.
REQ-016 anim_row and anim_col SHALL be decoded combinationally from the registered state and frame index, with zero latency after a state or frame register update.
REQ-017 On every clk, a jump_req or attack_req pulse SHALL set a sticky pending flag, which a later state transition consumes.
REQ-018 attack_req SHALL be dropped while in ATTACK, and jump_req SHALL be dropped while in JUMP, FALL or ATTACK.
REQ-019 State, frame-index and hold registers SHALL update only on clks where anim_tick is high.
REQ-020 In IDLE or RUN, priority on a tick SHALL be: attack pending -> ATTACK; else jump pending and on_ground -> JUMP; else !on_ground -> FALL; else move_req -> RUN; else IDLE.
REQ-021 Every state entry SHALL clear the frame index and hold count, and SHALL preempt any remaining hold immediately.
REQ-022 Entering ATTACK SHALL clear both pending flags; entering JUMP SHALL clear the jump pending flag.
REQ-023 JUMP SHALL go to FALL after its last frame expires.
REQ-024 FALL SHALL go to ATTACK if attack is pending; else, when on_ground, to RUN if move_req, otherwise IDLE.
REQ-025 ATTACK SHALL be non-interruptible.
REQ-026 After ATTACK's last frame expires, the next state SHALL be FALL if !on_ground, else RUN if move_req, else IDLE, and anim_done SHALL pulse on that same clk.
REQ-027 RUN's frame index SHALL wrap from 2 to 0.
REQ-028 busy SHALL equal (state==JUMP || state==ATTACK).

Reset
REQ-029 reset SHALL act on any clk, independent of anim_tick, and SHALL take priority over all other inputs.
REQ-030 After reset: state=IDLE, frame index=0, hold=0, pending flags=0, anim_row=0, anim_col=0, busy=0, anim_done=0.
REQ-031 Reset asserted mid-ATTACK SHALL abort the sequence without pulsing anim_done.

Configuration
REQ-032 With ANIM_HOLD_EN defined, a 5-bit hold counter SHALL count ticks 0..HOLD_TICKS-1, and a frame SHALL expire on the tick where hold==HOLD_TICKS-1.
REQ-033 With ANIM_HOLD_EN undefined, the hold counter SHALL be absent and every anim_tick SHALL expire the current frame.

Structure
REQ-034 The state enum, the frame-table constants (rows and columns) and the per-state frame counts SHALL reside in package fighter_anim_pkg.
REQ-035 Frame hold and expiry SHALL be a sub-module anim_frame_timer (inputs clk, reset, anim_tick, restart; output expire), instantiated once.

Verification
REQ-036 Reset, then 3 ticks with no requests and on_ground=1 -> (0,0), busy=0.
REQ-037 HOLD_EN off, on_ground=1, move_req=1, 4 ticks -> (30,0), (30,23), (30,46), (30,0).
REQ-038 HOLD_EN off, attack_req pulse between ticks in IDLE -> ATTACK frames (90,23), (120,0), (120,23), busy=1 throughout, then anim_done pulses and the state returns to IDLE.
REQ-039 attack_req and jump_req pulsed on the same clk in IDLE -> ATTACK entered and jump dropped; the state returns to IDLE, not JUMP.
REQ-040 HOLD_EN on with HOLD_TICKS=4: jump, then on_ground=0 -> (60,0) held 4 ticks, (60,23) held 4 ticks, then (90,0) held until on_ground=1.
REQ-041 reset asserted during ATTACK frame (120,0) with anim_tick=0 -> next clk shows (0,0) and IDLE, with anim_done=0.

Source files
------------

// File: rtl/fighter_anim_pkg.sv
// Shared types and sprite-sheet frame table for the fighter animation controller.
// Optional frame hold is enabled by defining ANIM_HOLD_EN.
package fighter_anim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_JUMP   = 3'd2,
    ST_FALL   = 3'd3,
    ST_ATTACK = 3'd4
  } anim_state_e;

  // Frames per state; the last frame index is count-1.
  localparam int unsigned IDLE_FRAMES   = 1;
  localparam int unsigned RUN_FRAMES    = 3;
  localparam int unsigned JUMP_FRAMES   = 2;
  localparam int unsigned FALL_FRAMES   = 1;
  localparam int unsigned ATTACK_FRAMES = 3;

  localparam int unsigned ROW_IDLE     = 0;
  localparam int unsigned ROW_RUN      = 30;
  localparam int unsigned ROW_JUMP     = 60;
  localparam int unsigned ROW_FALL     = 90;
  localparam int unsigned ROW_ATTACK_A = 90;
  localparam int unsigned ROW_ATTACK_B = 120;

  localparam int unsigned COL_0 = 0;
  localparam int unsigned COL_1 = 23;
  localparam int unsigned COL_2 = 46;

  function automatic logic [1:0] last_frame(input anim_state_e st);
    logic [1:0] idx;
    case (st)
      ST_RUN:    idx = 2'(RUN_FRAMES - 1);
      ST_JUMP:   idx = 2'(JUMP_FRAMES - 1);
      ST_FALL:   idx = 2'(FALL_FRAMES - 1);
      ST_ATTACK: idx = 2'(ATTACK_FRAMES - 1);
      default:   idx = 2'(IDLE_FRAMES - 1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/anim_frame_timer.sv
// Frame hold timer: pulses expire on the anim_tick that ends the current frame.
// With ANIM_HOLD_EN defined a frame lasts HOLD_TICKS ticks, otherwise one tick.
module anim_frame_timer #(
  parameter int HOLD_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic anim_tick,
  input  logic restart,
  output logic expire
);

`ifdef ANIM_HOLD_EN
  localparam logic [4:0] HOLD_LAST = 5'(HOLD_TICKS - 1);

  logic [4:0] hold_q;
  logic [4:0] hold_d;

  assign expire = anim_tick && (hold_q == HOLD_LAST);

  // A state entry restarts the count even if the old frame had ticks left.
  always_comb begin
    hold_d = hold_q;
    if (anim_tick) begin
      if (restart || expire) begin
        hold_d = 5'd0;
      end else begin
        hold_d = hold_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 5'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_timer_inputs;

  assign expire              = anim_tick;
  assign unused_timer_inputs = ^{clk, reset, restart, 5'(HOLD_TICKS)};
`endif

endmodule

// File: rtl/fighter_anim_controller.sv
// Fighter sprite animation controller: IDLE/RUN/JUMP/FALL/ATTACK with a frame table.
// Define ANIM_HOLD_EN to hold each frame for HOLD_TICKS anim_ticks.
module fighter_anim_controller
  import fighter_anim_pkg::*;
#(
  parameter int HOLD_TICKS = 4,
  parameter int COORD_W    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               anim_tick,
  input  logic               move_req,
  input  logic               jump_req,
  input  logic               attack_req,
  input  logic               on_ground,
  output logic [COORD_W-1:0] anim_row,
  output logic [COORD_W-1:0] anim_col,
  output logic               busy,
  output logic               anim_done,
  output anim_state_e        dbg_state
);

  anim_state_e state_q, state_d;
  logic [1:0]  frame_q, frame_d;
  logic        atk_pend_q, atk_pend_d;
  logic        jmp_pend_q, jmp_pend_d;
  logic        done_q, done_d;
  logic        expire;
  logic        restart;
  logic        last_q;
  logic        atk_set, jmp_set;
  logic        enter_atk, enter_jump;

  anim_frame_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .anim_tick(anim_tick),
    .restart  (restart),
    .expire   (expire)
  );

  assign last_q = (frame_q == last_frame(state_q));

  // Requests are dropped in states that cannot act on them.
  assign atk_set = attack_req && (state_q != ST_ATTACK);
  assign jmp_set = jump_req && (state_q == ST_IDLE || state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (anim_tick) begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (atk_pend_q) begin
            state_d = ST_ATTACK;
          end else if (jmp_pend_q && on_ground) begin
            state_d = ST_JUMP;
          end else if (!on_ground) begin
            state_d = ST_FALL;
          end else if (move_req) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_JUMP: begin
          if (expire && last_q) begin
            state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (atk_pend_q) begin
            state_d = ST_ATTACK;
          end else if (on_ground) begin
            state_d = move_req ? ST_RUN : ST_IDLE;
          end
        end
        ST_ATTACK: begin
          if (expire && last_q) begin
            done_d = 1'b1;
            if (!on_ground) begin
              state_d = ST_FALL;
            end else begin
              state_d = move_req ? ST_RUN : ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign restart    = anim_tick && (state_d != state_q);
  assign enter_atk  = restart && (state_d == ST_ATTACK);
  assign enter_jump = restart && (state_d == ST_JUMP);

  always_comb begin
    frame_d = frame_q;
    if (restart) begin
      frame_d = 2'd0;
    end else if (expire) begin
      case (state_q)
        ST_RUN:            frame_d = last_q ? 2'd0 : frame_q + 2'd1;
        ST_JUMP, ST_ATTACK: frame_d = last_q ? frame_q : frame_q + 2'd1;
        default:           frame_d = 2'd0;
      endcase
    end
  end

  always_comb begin
    atk_pend_d = (atk_pend_q && !enter_atk) || atk_set;
    jmp_pend_d = (jmp_pend_q && !(enter_atk || enter_jump)) || jmp_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= 2'd0;
      atk_pend_q <= 1'b0;
      jmp_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      atk_pend_q <= atk_pend_d;
      jmp_pend_q <= jmp_pend_d;
      done_q     <= done_d;
    end
  end

  // Sprite coordinates follow the registered state and frame with no extra delay.
  always_comb begin
    anim_row = COORD_W'(ROW_IDLE);
    anim_col = COORD_W'(COL_0);
    case (state_q)
      ST_RUN: begin
        anim_row = COORD_W'(ROW_RUN);
        case (frame_q)
          2'd1:    anim_col = COORD_W'(COL_1);
          2'd2:    anim_col = COORD_W'(COL_2);
          default: anim_col = COORD_W'(COL_0);
        endcase
      end
      ST_JUMP: begin
        anim_row = COORD_W'(ROW_JUMP);
        anim_col = (frame_q == 2'd1) ? COORD_W'(COL_1) : COORD_W'(COL_0);
      end
      ST_FALL: begin
        anim_row = COORD_W'(ROW_FALL);
        anim_col = COORD_W'(COL_0);
      end
      ST_ATTACK: begin
        case (frame_q)
          2'd1: begin
            anim_row = COORD_W'(ROW_ATTACK_B);
            anim_col = COORD_W'(COL_0);
          end
          2'd2: begin
            anim_row = COORD_W'(ROW_ATTACK_B);
            anim_col = COORD_W'(COL_1);
          end
          default: begin
            anim_row = COORD_W'(ROW_ATTACK_A);
            anim_col = COORD_W'(COL_1);
          end
        endcase
      end
      default: begin
        anim_row = COORD_W'(ROW_IDLE);
        anim_col = COORD_W'(COL_0);
      end
    endcase
  end

  assign busy      = (state_q == ST_JUMP) || (state_q == ST_ATTACK);
  assign anim_done = done_q;
  assign dbg_state = state_q;

endmodule
